// File: rtl/imm_gen_pipe_if.sv
// Decode-side handshake bundle for the immediate generator: the instruction
// entry going in and the generated immediate coming out.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  // Both directions use valid/ready: an entry moves on a rising edge where
  // valid && ready. A producer holds valid and its payload until accepted.
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ir;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport slave (
    input  in_valid, in_ir, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport master (
    output in_valid, in_ir, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational format decode feeding a
// two-entry (main + skid) output buffer with a registered in_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic [31:0]        ir;
  logic signed [31:0] imm32;
  logic               sel_err;
  entry_t             in_ent;

  entry_t m_q, m_d;
  entry_t k_q, k_d;
  logic   m_v_q, m_v_d;
  logic   k_v_q, k_v_d;
  logic   in_xfer;
  logic   out_xfer;

  assign ir = bus.in_ir;

  // Every format fits in 32 bits once sign-extended, so decode at 32 bits and
  // widen with a single signed cast; shamt/zimm stay positive so zext holds.
  always_comb begin
    imm32   = '0;
    sel_err = 1'b0;
    unique case (bus.in_sel)
      3'b000: imm32 = {{20{ir[31]}}, ir[31:20]};
      3'b001: imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      3'b010: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      3'b011: imm32 = {ir[31:12], 12'h000};
      3'b100: imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      3'b101: imm32 = (XLEN == 64) ? {26'd0, ir[25:20]} : {27'd0, ir[24:20]};
      3'b110: imm32 = {27'd0, ir[19:15]};
      default: begin
        imm32   = '0;
        sel_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    in_ent.imm = XLEN'(imm32);
    in_ent.tag = bus.in_tag;
    in_ent.err = sel_err;
  end

  assign in_xfer  = bus.in_valid && !k_v_q;
  assign out_xfer = m_v_q && bus.out_ready;

  // M refills from K first to keep FIFO order; K only fills when M is stuck.
  always_comb begin
    m_d   = m_q;
    k_d   = k_q;
    m_v_d = m_v_q;
    k_v_d = k_v_q;
    if (flush) begin
      m_v_d = 1'b0;
      k_v_d = 1'b0;
    end else if (!m_v_q || out_xfer) begin
      if (k_v_q) begin
        m_d   = k_q;
        m_v_d = 1'b1;
        k_v_d = in_xfer;
        if (in_xfer) begin
          k_d = in_ent;
        end
      end else if (in_xfer) begin
        m_d   = in_ent;
        m_v_d = 1'b1;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      k_d   = in_ent;
      k_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      k_q   <= '0;
      m_v_q <= 1'b0;
      k_v_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      k_q   <= k_d;
      m_v_q <= m_v_d;
      k_v_q <= k_v_d;
    end
  end

  // in_ready is a pure flop output so upstream never sees out_ready ripple.
  assign bus.in_ready  = !k_v_q;
  assign bus.out_valid = m_v_q;
  assign bus.out_imm   = m_q.imm;
  assign bus.out_tag   = m_q.tag;
  assign bus.out_err   = m_q.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep,
// each with its own expected-entry queue and output monitor.
module tb_imm_gen_pipe;
  localparam int TAG_W = 5;
  localparam int E     = 1 + TAG_W + 64;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64)
  );

  int checks = 0;
  int errors = 0;

  // Entries accepted and not yet consumed, packed {err, tag, imm64}.
  logic [E-1:0] exp32_q[$];
  logic [E-1:0] exp64_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference immediate from the format rules as signed integer arithmetic.
  function automatic logic [64:0] ref_imm(input logic [31:0] ir, input logic [2:0] sel,
                                          input bit is64);
    longint v;
    logic   err;
    v   = 0;
    err = 1'b0;
    case (sel)
      3'd0: begin
        v = longint'(ir[31:20]);
        if (ir[31]) v = v - 4096;
      end
      3'd1: begin
        v = longint'(ir[31:25]) * 32 + longint'(ir[11:7]);
        if (ir[31]) v = v - 4096;
      end
      3'd2: begin
        v = longint'(ir[31]) * 4096 + longint'(ir[7]) * 2048
          + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
        if (ir[31]) v = v - 8192;
      end
      3'd3: begin
        v = longint'(ir[31:12]) * 4096;
        if (ir[31]) v = v - 64'sd4294967296;
      end
      3'd4: begin
        v = longint'(ir[31]) * 1048576 + longint'(ir[19:12]) * 4096
          + longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2;
        if (ir[31]) v = v - 2097152;
      end
      3'd5: v = is64 ? longint'(ir[25:20]) : longint'(ir[24:20]);
      3'd6: v = longint'(ir[19:15]);
      default: err = 1'b1;
    endcase
    return {err, v[63:0]};
  endfunction

  function automatic logic [E-1:0] make_entry(input logic [31:0] ir, input logic [2:0] sel,
                                              input logic [TAG_W-1:0] tag, input bit is64);
    logic [64:0] r;
    logic [63:0] imm;
    r   = ref_imm(ir, sel, is64);
    imm = is64 ? r[63:0] : {32'd0, r[31:0]};
    return {r[64], tag, imm};
  endfunction

  // One clock of stimulus; queues are updated right after the edge it targets.
  task automatic drive_cycle(input logic v, input logic [31:0] ir, input logic [2:0] sel,
                             input logic [TAG_W-1:0] tag, input logic ordy, input logic fl,
                             output logic acc);
    logic acc64;
    if32.in_valid = v;  if64.in_valid = v;
    if32.in_ir = ir;    if64.in_ir = ir;
    if32.in_sel = sel;  if64.in_sel = sel;
    if32.in_tag = tag;  if64.in_tag = tag;
    if32.out_ready = ordy; if64.out_ready = ordy;
    flush = fl;
    acc   = v && !fl && (exp32_q.size() < 2);
    acc64 = v && !fl && (exp64_q.size() < 2);
    @(posedge clk);
    #1;
    if (fl) begin
      exp32_q.delete();
      exp64_q.delete();
    end else begin
      if (acc) exp32_q.push_back(make_entry(ir, sel, tag, 1'b0));
      if (acc64) exp64_q.push_back(make_entry(ir, sel, tag, 1'b1));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ov32"},  64'(if32.out_valid), 64'd0);
    check({tag, "_ir32"},  64'(if32.in_ready),  64'd1);
    check({tag, "_imm32"}, 64'(if32.out_imm),   64'd0);
    check({tag, "_tag32"}, 64'(if32.out_tag),   64'd0);
    check({tag, "_err32"}, 64'(if32.out_err),   64'd0);
    check({tag, "_ov64"},  64'(if64.out_valid), 64'd0);
    check({tag, "_ir64"},  64'(if64.in_ready),  64'd1);
    check({tag, "_imm64"}, if64.out_imm,        64'd0);
    check({tag, "_tag64"}, 64'(if64.out_tag),   64'd0);
    check({tag, "_err64"}, 64'(if64.out_err),   64'd0);
  endtask

  logic [E-1:0] e32;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("in_ready32", 64'(if32.in_ready), 64'(exp32_q.size() < 2));
      check("out_valid32", 64'(if32.out_valid), 64'(exp32_q.size() > 0));
      if (if32.out_valid === 1'b1 && exp32_q.size() > 0) begin
        e32 = exp32_q[0];
        check("imm32", {32'd0, if32.out_imm}, e32[63:0]);
        check("tag32", 64'(if32.out_tag), 64'(e32[68:64]));
        check("err32", 64'(if32.out_err), 64'(e32[69]));
        if (if32.out_ready) void'(exp32_q.pop_front());
      end
    end
  end

  logic [E-1:0] e64;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("in_ready64", 64'(if64.in_ready), 64'(exp64_q.size() < 2));
      check("out_valid64", 64'(if64.out_valid), 64'(exp64_q.size() > 0));
      if (if64.out_valid === 1'b1 && exp64_q.size() > 0) begin
        e64 = exp64_q[0];
        check("imm64", if64.out_imm, e64[63:0]);
        check("tag64", 64'(if64.out_tag), 64'(e64[68:64]));
        check("err64", 64'(if64.out_err), 64'(e64[69]));
        if (if64.out_ready) void'(exp64_q.pop_front());
      end
    end
  end

  logic [31:0] dir_ir[12] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7,
                              32'h001000EF, 32'h01F0D093, 32'h000FD073, 32'hDEADBEEF,
                              32'h800000B7, 32'h03F0D093, 32'h80000FEF, 32'h7FF00093};
  logic [2:0]  dir_sel[12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                               3'd3, 3'd5, 3'd4, 3'd0};

  initial begin
    logic        acc;
    logic [31:0] bp_ir[6];
    int          sent;
    logic        cur_v;
    logic [31:0] cur_ir;
    logic [2:0]  cur_sel;
    logic [4:0]  cur_tag;
    logic        fl;

    rst_n = 1'b0;
    flush = 1'b0;
    if32.in_valid = 1'b0; if64.in_valid = 1'b0;
    if32.in_ir = '0;      if64.in_ir = '0;
    if32.in_sel = '0;     if64.in_sel = '0;
    if32.in_tag = '0;     if64.in_tag = '0;
    if32.out_ready = 1'b0; if64.out_ready = 1'b0;
    #2;
    check_reset("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed formats, back to back with the sink always ready.
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, dir_ir[i], dir_sel[i], 5'(i + 1), 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);

    // Backpressure: stream tags 1..6, sink stalls after the first cycle.
    for (int i = 0; i < 6; i++) bp_ir[i] = $urandom;
    sent = 0;
    for (int c = 0; c < 40 && sent < 6; c++) begin
      drive_cycle(1'b1, bp_ir[sent], 3'(sent % 7), 5'(sent + 1), (c == 0) || (c >= 6), 1'b0, acc);
      if (acc) sent++;
    end
    check("bp_sent", 64'(sent), 64'd6);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);

    // Flush with both slots full and a new entry offered.
    drive_cycle(1'b1, 32'hFFF00093, 3'd0, 5'd10, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 32'hFE20AE23, 3'd1, 5'd11, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 32'h123450B7, 3'd3, 5'd12, 1'b0, 1'b1, acc);
    check("flush_ov32", 64'(if32.out_valid), 64'd0);
    check("flush_ir32", 64'(if32.in_ready), 64'd1);
    check("flush_ov64", 64'(if64.out_valid), 64'd0);
    drive_cycle(1'b1, 32'h001000EF, 3'd4, 5'd13, 1'b1, 1'b0, acc);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);

    // Random traffic; payload held until accepted.
    cur_v = 1'b0; cur_ir = '0; cur_sel = '0; cur_tag = '0;
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!cur_v || acc) begin
        cur_v   = ($urandom_range(0, 3) != 0);
        cur_ir  = $urandom;
        cur_sel = 3'($urandom_range(0, 7));
        cur_tag = 5'($urandom_range(0, 31));
      end
      fl = ($urandom_range(0, 40) == 0);
      drive_cycle(cur_v, cur_ir, cur_sel, cur_tag, ($urandom_range(0, 3) != 0), fl, acc);
      if (fl) acc = 1'b1;
    end

    // Asynchronous reset between edges with entries held.
    drive_cycle(1'b1, 32'hFE000CE3, 3'd2, 5'd21, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 32'h01F0D093, 3'd5, 5'd22, 1'b0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    exp32_q.delete();
    exp64_q.delete();
    #1;
    check_reset("mid");
    if32.in_valid = 1'b0; if64.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 32'h800000B7, 3'd3, 5'd23, 1'b1, 1'b0, acc);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);

    for (int c = 0; c < 20 && (exp32_q.size() > 0 || exp64_q.size() > 0); c++)
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
    check("drain32", 64'(exp32_q.size()), 64'd0);
    check("drain64", 64'(exp64_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
